// File: rtl/ex_pkg.sv
// ex_pkg: shared opcodes, selects and muldiv FSM states for the execute stage
package ex_pkg;
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLT  = 3'd4;
    localparam logic [2:0] BR_BGE  = 3'd5;
    localparam logic [2:0] BR_BLTU = 3'd6;
    localparam logic [2:0] BR_BGEU = 3'd7;

    localparam logic [1:0] FWD_IDEX  = 2'd0;
    localparam logic [1:0] FWD_MEM   = 2'd1;
    localparam logic [1:0] FWD_WB    = 2'd2;
    localparam logic [1:0] FWD_IDEX2 = 2'd3;

    typedef enum logic [1:0] {MD_IDLE, MD_ACT_MUL, MD_ACT_DIV, MD_DONE} md_state_e;

    function automatic logic [31:0] cneg(input logic [31:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with operand latching and special-case divides
module muldiv_unit
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    md_state_e state, state_nx;
    logic [XLEN-1:0] a_q, b_q, quo_q, rem_q, res_q;
    logic [2:0] op_q;
    logic [5:0] cnt;
    logic div_signed_in, special_in, neg_a, neg_b, last, ge, mul_sa, mul_sb;
    logic [XLEN-1:0] min_int, spec_res, dvs, quo_n, rem_n, div_res, mul_res;
    logic [XLEN:0] rem_sh, diff;
    logic [2*XLEN-1:0] ma, mb, prod;

    assign min_int = {1'b1, {(XLEN-1){1'b0}}};
    assign div_signed_in = !op[0];
    assign special_in = b == '0 || (div_signed_in && a == min_int && b == '1);
    assign spec_res = b == '0 ? (op[1] ? a : '1) : (op[1] ? '0 : min_int);

    // Sign-extending both factors to 64 bits makes one modular multiply cover all four variants
    assign mul_sa = op_q != MD_MULHU;
    assign mul_sb = op_q == MD_MUL || op_q == MD_MULH;
    assign ma = {{XLEN{mul_sa & a_q[XLEN-1]}}, a_q};
    assign mb = {{XLEN{mul_sb & b_q[XLEN-1]}}, b_q};
    assign prod = ma * mb;
    assign mul_res = op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Restoring divide on magnitudes; the dividend shifts out of quo_q as quotient bits shift in
    assign neg_a = !op_q[0] && a_q[XLEN-1];
    assign neg_b = !op_q[0] && b_q[XLEN-1];
    assign dvs = cneg(b_q, neg_b);
    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff = rem_sh - {1'b0, dvs};
    assign ge = !diff[XLEN];
    assign rem_n = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_n = {quo_q[XLEN-2:0], ge};
    assign div_res = op_q[1] ? cneg(rem_n, neg_a) : cneg(quo_n, neg_a ^ neg_b);
    assign last = cnt == 6'(DIV_ITERS - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE: if (start) state_nx = !op[2] ? MD_ACT_MUL : special_in ? MD_DONE : MD_ACT_DIV;
            MD_ACT_MUL: state_nx = MD_DONE;
            MD_ACT_DIV: state_nx = last ? MD_DONE : MD_ACT_DIV;
            default: state_nx = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            res_q <= '0;
            cnt <= '0;
        end else begin
            if (state == MD_IDLE && start) begin
                a_q <= a;
                b_q <= b;
                op_q <= op;
                quo_q <= cneg(a, div_signed_in && a[XLEN-1]);
                rem_q <= '0;
                cnt <= '0;
                if (op[2] && special_in) res_q <= spec_res;
            end
            if (state == MD_ACT_MUL) res_q <= mul_res;
            if (state == MD_ACT_DIV) begin
                rem_q <= rem_n;
                quo_q <= quo_n;
                cnt <= cnt + 6'd1;
                if (last) res_q <= div_res;
            end
        end
    end

    assign done = state == MD_DONE;
    assign busy = start && !done;
    assign result = res_q;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: operand forwarding, ALU, branch resolution, muldiv stall control and the EX/MEM register
module ex_stage
    import ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_rs1_val,
    input  logic [XLEN-1:0] ex_rs2_val,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [4:0]      ex_rd,
    input  logic            ex_RW,
    input  logic            ex_MR,
    input  logic            ex_MW,
    input  logic            ex_branch,
    input  logic            ex_ALUsrc,
    input  logic            ex_is_muldiv,
    input  logic [3:0]      ex_alu_sel,
    input  logic [2:0]      ex_muldiv_op,
    input  logic [2:0]      ex_funct3,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] mem_fwd_val,
    input  logic [XLEN-1:0] wb_fwd_val,
    output logic            ex_stall,
    output logic            branch_taken,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_val,
    output logic [4:0]      mem_rd,
    output logic [2:0]      mem_funct3,
    output logic            mem_RW,
    output logic            mem_MR,
    output logic            mem_MW
);
    logic [XLEN-1:0] op_a, op_b, store_val, alu_res, md_result;
    logic [4:0] shamt;
    logic md_busy, md_done, br_cond;

    assign op_a = fwd_a_sel == FWD_MEM ? mem_fwd_val : fwd_a_sel == FWD_WB ? wb_fwd_val : ex_rs1_val;
    assign store_val = fwd_b_sel == FWD_MEM ? mem_fwd_val : fwd_b_sel == FWD_WB ? wb_fwd_val : ex_rs2_val;
    assign op_b = ex_ALUsrc ? ex_imm : store_val;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        case (ex_alu_sel)
            ALU_ADD:   alu_res = op_a + op_b;
            ALU_SUB:   alu_res = op_a - op_b;
            ALU_SLL:   alu_res = op_a << shamt;
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:   alu_res = op_a ^ op_b;
            ALU_SRL:   alu_res = op_a >> shamt;
            ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:    alu_res = op_a | op_b;
            ALU_AND:   alu_res = op_a & op_b;
            ALU_PASSB: alu_res = op_b;
            default:   alu_res = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (ex_funct3)
            BR_BEQ:  br_cond = op_a == op_b;
            BR_BNE:  br_cond = op_a != op_b;
            BR_BLT:  br_cond = $signed(op_a) < $signed(op_b);
            BR_BGE:  br_cond = $signed(op_a) >= $signed(op_b);
            BR_BLTU: br_cond = op_a < op_b;
            BR_BGEU: br_cond = op_a >= op_b;
            default: br_cond = 1'b0;
        endcase
    end

    // A stalled instruction must not redirect fetch before it actually leaves EX
    assign branch_taken = ex_branch && br_cond && !ex_stall;
    assign branch_target = ex_pc + ex_imm;
    assign ex_stall = md_busy;

    muldiv_unit #(.XLEN(XLEN), .DIV_ITERS(DIV_ITERS)) u_muldiv (
        .clk(clk),
        .rst(rst),
        .start(ex_is_muldiv),
        .a(op_a),
        .b(op_b),
        .op(ex_muldiv_op),
        .busy(md_busy),
        .done(md_done),
        .result(md_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_alu_result <= '0;
            mem_store_val <= '0;
            mem_rd <= '0;
            mem_funct3 <= '0;
            mem_RW <= 1'b0;
            mem_MR <= 1'b0;
            mem_MW <= 1'b0;
        end else if (ex_stall) begin
            mem_rd <= '0;
            mem_RW <= 1'b0;
            mem_MR <= 1'b0;
            mem_MW <= 1'b0;
        end else begin
            mem_alu_result <= ex_is_muldiv && md_done ? md_result : alu_res;
            mem_store_val <= store_val;
            mem_rd <= ex_rd;
            mem_funct3 <= ex_funct3;
            mem_RW <= ex_RW;
            mem_MR <= ex_MR;
            mem_MW <= ex_MW;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
    import ex_pkg::*;

    logic clk, rst;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, mem_fwd_val, wb_fwd_val;
    logic [4:0] ex_rd;
    logic ex_RW, ex_MR, ex_MW, ex_branch, ex_ALUsrc, ex_is_muldiv;
    logic [3:0] ex_alu_sel;
    logic [2:0] ex_muldiv_op, ex_funct3;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic ex_stall, branch_taken, mem_RW, mem_MR, mem_MW;
    logic [31:0] branch_target, mem_alu_result, mem_store_val;
    logic [4:0] mem_rd;
    logic [2:0] mem_funct3;
    int checks = 0;
    int failures = 0;

    logic [3:0]  alu_sel_t [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
    logic [31:0] alu_a_t [12] = '{32'd5, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h80000000,
                                  32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1234, 32'd5, 32'd9};
    logic [31:0] alu_b_t [12] = '{32'd7, 32'h3F, 32'd1, 32'd1, 32'hFF00FF00, 32'd4,
                                  32'd4, 32'h0F000000, 32'hFF00FF00, 32'hABCD, 32'd7, 32'd9};
    logic [31:0] alu_e_t [12] = '{32'hFFFFFFFE, 32'h80000000, 32'd1, 32'd0, 32'h0FF00FF0, 32'h08000000,
                                  32'hF8000000, 32'hFFF0F0F0, 32'hF000F000, 32'hABCD, 32'd0, 32'd0};

    logic [2:0]  br_f3_t [8] = '{3'd4, 3'd6, 3'd0, 3'd1, 3'd5, 3'd7, 3'd2, 3'd3};
    logic [31:0] br_a_t [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd1, 32'd1, 32'd5, 32'd5};
    logic [31:0] br_b_t [8] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd6};
    logic        br_e_t [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    ex_stage dut (
        .clk(clk), .rst(rst), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_RW(ex_RW), .ex_MR(ex_MR), .ex_MW(ex_MW),
        .ex_branch(ex_branch), .ex_ALUsrc(ex_ALUsrc), .ex_is_muldiv(ex_is_muldiv),
        .ex_alu_sel(ex_alu_sel), .ex_muldiv_op(ex_muldiv_op), .ex_funct3(ex_funct3),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .ex_stall(ex_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_alu_result(mem_alu_result), .mem_store_val(mem_store_val), .mem_rd(mem_rd),
        .mem_funct3(mem_funct3), .mem_RW(mem_RW), .mem_MR(mem_MR), .mem_MW(mem_MW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_nop;
        ex_pc = '0; ex_rs1_val = '0; ex_rs2_val = '0; ex_imm = '0; ex_rd = '0;
        ex_RW = 0; ex_MR = 0; ex_MW = 0; ex_branch = 0; ex_ALUsrc = 0; ex_is_muldiv = 0;
        ex_alu_sel = '0; ex_muldiv_op = '0; ex_funct3 = '0; fwd_a_sel = '0; fwd_b_sel = '0;
        mem_fwd_val = '0; wb_fwd_val = '0;
    endtask

    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_stall, input string name);
        int n;
        logic bub;
        set_nop;
        ex_is_muldiv = 1; ex_muldiv_op = op; ex_rs1_val = a; ex_rs2_val = b; ex_RW = 1; ex_rd = 5'd7;
        #1;
        n = 0;
        bub = 0;
        while (ex_stall && n < 100) begin
            if (n > 0 && (mem_RW !== 1'b0 || mem_rd !== 5'd0)) bub = 1;
            n++;
            @(negedge clk); #1;
        end
        checks++;
        if (n != exp_stall) begin failures++; $display("FAIL %s_stall_cycles got=%0d exp=%0d", name, n, exp_stall); end
        checks++;
        if (bub !== 1'b0) begin failures++; $display("FAIL %s_bubble got=RW/rd nonzero during stall exp=0", name); end
        @(negedge clk); #1;
        checks++;
        if (mem_alu_result !== exp) begin failures++; $display("FAIL %s_result got=%h exp=%h", name, mem_alu_result, exp); end
        checks++;
        if ({mem_RW, mem_rd} !== {1'b1, 5'd7}) begin failures++; $display("FAIL %s_ctrl got=%b/%0d exp=1/7", name, mem_RW, mem_rd); end
    endtask

    task automatic test_reset;
        rst = 1;
        set_nop;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({mem_alu_result, mem_store_val, mem_rd, mem_funct3, mem_RW, mem_MR, mem_MW} !== '0) begin
            failures++; $display("FAIL reset_outputs got=%h/%h/%0d exp=0", mem_alu_result, mem_store_val, mem_rd);
        end
        checks++;
        if (ex_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", ex_stall); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_forwarding;
        set_nop;
        fwd_a_sel = FWD_MEM; mem_fwd_val = 32'd5; ex_rs2_val = 32'd7; ex_alu_sel = ALU_ADD; ex_RW = 1; ex_rd = 5'd3;
        @(negedge clk); #1;
        checks++;
        if ({mem_alu_result, mem_RW, mem_rd} !== {32'd12, 1'b1, 5'd3}) begin
            failures++; $display("FAIL fwd_add got=%0d/%b/%0d exp=12/1/3", mem_alu_result, mem_RW, mem_rd);
        end
        set_nop;
        fwd_a_sel = FWD_WB; wb_fwd_val = 32'd100; fwd_b_sel = FWD_MEM; mem_fwd_val = 32'd1; ex_rs1_val = 32'd50;
        ex_alu_sel = ALU_SUB; ex_funct3 = 3'd2;
        @(negedge clk); #1;
        checks++;
        if ({mem_alu_result, mem_store_val, mem_funct3} !== {32'd99, 32'd1, 3'd2}) begin
            failures++; $display("FAIL fwd_sub got=%0d/%0d/%0d exp=99/1/2", mem_alu_result, mem_store_val, mem_funct3);
        end
        set_nop;
        fwd_a_sel = FWD_IDEX2; ex_rs1_val = 32'h1000; ex_ALUsrc = 1; ex_imm = 32'h10;
        fwd_b_sel = FWD_WB; wb_fwd_val = 32'h55; ex_MW = 1;
        @(negedge clk); #1;
        checks++;
        if ({mem_alu_result, mem_store_val, mem_MW, mem_RW} !== {32'h1010, 32'h55, 1'b1, 1'b0}) begin
            failures++; $display("FAIL fwd_store got=%h/%h/%b exp=1010/55/1", mem_alu_result, mem_store_val, mem_MW);
        end
    endtask

    task automatic test_alu;
        for (int i = 0; i < 12; i++) begin
            set_nop;
            ex_alu_sel = alu_sel_t[i]; ex_rs1_val = alu_a_t[i]; ex_rs2_val = alu_b_t[i]; ex_RW = 1;
            @(negedge clk); #1;
            checks++;
            if (mem_alu_result !== alu_e_t[i]) begin
                failures++; $display("FAIL alu_sel%0d got=%h exp=%h", alu_sel_t[i], mem_alu_result, alu_e_t[i]);
            end
        end
    endtask

    task automatic test_branch;
        for (int i = 0; i < 8; i++) begin
            set_nop;
            ex_branch = 1; ex_funct3 = br_f3_t[i]; ex_rs1_val = br_a_t[i]; ex_rs2_val = br_b_t[i];
            ex_pc = 32'h100; ex_imm = 32'h20;
            #1;
            checks++;
            if (branch_taken !== br_e_t[i]) begin
                failures++; $display("FAIL branch_f3_%0d got=%b exp=%b", br_f3_t[i], branch_taken, br_e_t[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (branch_target !== 32'h120) begin failures++; $display("FAIL branch_target got=%h exp=120", branch_target); end
        set_nop;
        ex_branch = 1; ex_funct3 = BR_BEQ; ex_rs1_val = 32'd5; ex_rs2_val = 32'd5; ex_is_muldiv = 1; ex_muldiv_op = MD_MUL;
        #1;
        checks++;
        if ({ex_stall, branch_taken} !== 2'b10) begin
            failures++; $display("FAIL branch_during_stall got=%b%b exp=10", ex_stall, branch_taken);
        end
        set_nop;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_div;
        run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div_neg7_2");
        run_md(MD_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem_neg7_2");
        set_nop;
    endtask

    task automatic test_special;
        run_md(MD_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 1, "divu_by0");
        run_md(MD_REMU, 32'd9, 32'd0, 32'd9, 1, "remu_by0");
        run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
        run_md(MD_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");
        run_md(MD_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33, "divu_big");
        set_nop;
    endtask

    task automatic test_mul;
        run_md(MD_MUL, 32'd3, 32'd4, 32'd12, 2, "mul_3x4");
        run_md(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, "mulhu_max");
        run_md(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, "mulhsu_neg");
        set_nop;
        ex_is_muldiv = 1; ex_muldiv_op = MD_MULH; fwd_a_sel = FWD_WB; fwd_b_sel = FWD_WB;
        wb_fwd_val = 32'h80000000; ex_RW = 1; ex_rd = 5'd7;
        @(negedge clk);
        wb_fwd_val = 32'd0;
        #1;
        checks++;
        if (ex_stall !== 1'b1) begin failures++; $display("FAIL mulh_stall2 got=%b exp=1", ex_stall); end
        @(negedge clk); #1;
        checks++;
        if (ex_stall !== 1'b0) begin failures++; $display("FAIL mulh_done got=%b exp=0", ex_stall); end
        @(negedge clk); #1;
        checks++;
        if (mem_alu_result !== 32'h40000000) begin
            failures++; $display("FAIL mulh_latched got=%h exp=40000000", mem_alu_result);
        end
        set_nop;
    endtask

    task automatic test_back_to_back;
        run_md(MD_DIVU, 32'd100, 32'd7, 32'd14, 33, "b2b_divu");
        run_md(MD_REMU, 32'd100, 32'd7, 32'd2, 33, "b2b_remu");
        run_md(MD_MUL, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFB, 2, "b2b_mul");
        set_nop;
    endtask

    task automatic test_async_reset;
        set_nop;
        ex_rs1_val = 32'd10; ex_rs2_val = 32'd20; ex_RW = 1; ex_rd = 5'd9; ex_funct3 = 3'd5; ex_alu_sel = ALU_ADD;
        @(negedge clk); #1;
        checks++;
        if (mem_alu_result !== 32'd30) begin failures++; $display("FAIL prereset_add got=%0d exp=30", mem_alu_result); end
        ex_is_muldiv = 1; ex_muldiv_op = MD_DIV;
        repeat (10) @(negedge clk);
        #1 rst = 1;
        #1;
        checks++;
        if ({mem_alu_result, mem_store_val, mem_rd, mem_funct3, mem_RW, mem_MR, mem_MW} !== '0) begin
            failures++; $display("FAIL async_reset_outputs got=%h/%h/%0d/%0d exp=0", mem_alu_result, mem_store_val, mem_rd, mem_funct3);
        end
        checks++;
        if (ex_stall !== 1'b1) begin failures++; $display("FAIL async_reset_stall got=%b exp=1", ex_stall); end
        set_nop;
        @(negedge clk);
        rst = 0;
        #1;
        run_md(MD_MUL, 32'd3, 32'd4, 32'd12, 2, "mul_after_rst");
        set_nop;
    endtask

    initial begin
        test_reset;
        test_forwarding;
        test_alu;
        test_branch;
        test_div;
        test_special;
        test_mul;
        test_back_to_back;
        test_async_reset;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage: consumes ID/EX register outputs, selects forwarded operands, computes ALU results and resolves branches.
- Runs RV32M multiply/divide through an iterative unit that stalls the front end while busy.
- Registers results into the EX/MEM pipeline register, feeding the MEM stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DIV_ITERS, 32, restoring-divider iterations; must equal XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  in  32 each  from ID/EX.
- ex_rd  in  5  destination register.
- ex_RW, ex_MR, ex_MW, ex_branch, ex_ALUsrc, ex_is_muldiv  in  1 each  control bits.
- ex_alu_sel  in  4  ALU operation.
- ex_muldiv_op  in  3  M-extension op.
- ex_funct3  in  3  branch condition / memory access size.
- fwd_a_sel, fwd_b_sel  in  2 each  operand source: 0=ID/EX, 1=MEM, 2=WB, 3=ID/EX.
- mem_fwd_val, wb_fwd_val  in  32 each  forwarded data.
- ex_stall  out  1  hold IF/ID and ID/EX (their enable = !ex_stall).
- branch_taken  out  1  redirect PC and flush IF/ID and ID/EX.
- branch_target  out  32  ex_pc + ex_imm.
- mem_alu_result, mem_store_val  out  32 each  EX/MEM register outputs.
- mem_rd  out  5  EX/MEM register output.
- mem_funct3  out  3  EX/MEM register output.
- mem_RW, mem_MR, mem_MW  out  1 each  EX/MEM register outputs.

Behaviour:
- Operands: A = fwd(rs1), B = ALUsrc ? imm : fwd(rs2); store value = fwd(rs2).
- ALU (combinational) per ex_alu_sel: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB. Shifts use B[4:0]. Undefined codes give 0.
- Branch (combinational): branch_taken = ex_branch && cond(funct3). Conditions: 0 BEQ, 1 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU; 2 and 3 give not taken. branch_taken is forced 0 while ex_stall=1.
- Muldiv FSM states: IDLE, MUL, DIV, DONE.
- IDLE, ex_is_muldiv=1:
  - Latch A, B and op into internal registers. Later forwarding changes are ignored.
  - op 0–3 → MUL. op 4–7 → DIV.
  - Divisor 0 or signed overflow (0x80000000 / -1) → DONE directly with the special result.
- MUL: one cycle; latch the 64-bit product (signedness per op: MUL, MULH, MULHSU, MULHU) → DONE.
- DIV: restoring divide on magnitudes, one quotient bit per cycle, DIV_ITERS cycles. Fix up signs (quotient sign = sA^sB, remainder sign = sA) → DONE.
- DONE: result valid; → IDLE next cycle.
- ex_stall = ex_is_muldiv && state != DONE (combinational).
- Latency, instruction first present at cycle T:
  - MUL: stall at T and T+1, DONE at T+2.
  - DIV: stall T..T+32, DONE at T+33.
  - Special-case divide: stall at T, DONE at T+1.
- Special results:
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU remainder = dividend.
  - Overflow: quotient 0x80000000, remainder 0.
- EX/MEM register:
  - ex_stall=1: insert bubble (mem_RW, mem_MR, mem_MW = 0, mem_rd = 0). Data fields don't-care; hold them.
  - Otherwise capture: result = muldiv result if ex_is_muldiv, else ALU result; plus store value, rd, funct3, RW, MR, MW.
- Reset (asynchronous, any time, including mid-divide): FSM → IDLE, all mem_* outputs and internal registers → 0. ex_stall and branch_taken then follow their combinational inputs.
- Back-to-back muldiv: DONE → IDLE, and the next muldiv starts in that IDLE cycle with no extra bubble.

Decomposition:
- Shared package ex_pkg:
  - ALU_* opcode constants (4-bit).
  - MD_* muldiv op constants (3-bit).
  - BR_* funct3 constants.
  - FWD_* select constants.
  - FSM state enum.
- One sub-module, muldiv_unit: FSM, operand latches, shifter/divider, special cases. Ports: start, a, b, op, busy, done, result.
- ALU, branch compare and EX/MEM register stay in ex_stage.

Test Plan:
- ADD: fwd_a_sel=1, mem_fwd_val=5, ex_rs2_val=7, alu_sel=0 → next cycle mem_alu_result=12, mem_RW=1.
- BLT: funct3=4, A=0xFFFFFFFF, B=1, pc=0x100, imm=0x20 → branch_taken=1 and branch_target=0x120, same cycle. Same operands with BLTU (funct3=6) → branch_taken=0.
- DIV: -7/2 → ex_stall high exactly 33 cycles, mem_RW=0 during stall, then mem_alu_result=0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- Special divides: DIVU 9/0 → 0xFFFFFFFF after 1 stall cycle. DIV 0x80000000/-1 → 0x80000000. REM 0x80000000/-1 → 0.
- MULH 0x80000000 × 0x80000000 → stall 2 cycles, result 0x40000000. Changing wb_fwd_val mid-stall does not alter the result.
- Assert rst at cycle 10 of a DIV → FSM IDLE and all mem_* = 0 immediately. After rst release, a new MUL 3×4 → 12.
